// File: rtl/ntsc_cvbs_enc.sv
// ntsc_cvbs_enc: NTSC composite video level encoder at 4fsc.
// Takes the timing generator's SYNC/BLANK/BURST/FI strobes and a YUV pixel
// stream and produces a 10-bit DAC code. The subcarrier comes from direct
// 4fsc sampling: the chroma term rotates +U, +V, -U, -V. Color-frame phase
// is locked to the rising edge of the FI field flag.
// Build option: define NTSC_CVBS_SETUP_EN for 7.5 IRE setup (black = 298).
// Without it there is no setup and black sits at blanking level (256).
// Latency is three enabled cycles.

module ntsc_cvbs_enc (
    input  logic       CK_i,
    input  logic       AR_i,
    input  logic       CK_EE_i,
    input  logic       SYNC_i,
    input  logic       BLANK_i,
    input  logic       BURST_i,
    input  logic       FI_i,
    input  logic [7:0] Y_i,
    input  logic [7:0] U_i,
    input  logic [7:0] V_i,
    output logic [9:0] CVBS_o,
    output logic [1:0] PH_o,
    output logic       CF_o
);

    localparam logic [9:0] SYNC_TIP  = 10'd16;
    localparam logic [9:0] BLANK_LVL = 10'd256;
`ifdef NTSC_CVBS_SETUP_EN
    localparam logic [9:0] BLACK     = 10'd298;
`else
    localparam logic [9:0] BLACK     = 10'd256;
`endif
    localparam logic signed [8:0] BURST_AMP = 9'sd112;

    typedef enum logic [1:0] {
        SEL_SYNC   = 2'd0,
        SEL_BURST  = 2'd1,
        SEL_BLANK  = 2'd2,
        SEL_ACTIVE = 2'd3
    } sel_t;

    // Frame/phase state
    logic       fi_d;
    logic       cf;
    logic [1:0] ph;
    logic       fi_rise;
    logic [1:0] ph_a;

    // Stage 1 registers
    logic       s1_sync;
    logic       s1_blank;
    logic       s1_burst;
    logic [7:0] s1_y;
    logic [7:0] s1_u;
    logic [7:0] s1_v;
    logic [1:0] s1_ph;

    // Stage 2 combinational and registers
    logic [9:0]        luma_code;
    logic signed [8:0] u9;
    logic signed [8:0] v9;
    logic signed [8:0] chroma_term;
    logic signed [8:0] burst_term;
    logic signed [8:0] term;
    sel_t              sel;
    logic [9:0]        s2_luma;
    logic signed [8:0] s2_term;
    sel_t              s2_sel;
    logic [1:0]        s2_ph;

    // Stage 3 combinational
    logic signed [11:0] sum;
    logic [9:0]         sat;

    // A new field with the color frame set restarts the subcarrier at phase 0
    assign fi_rise = FI_i & ~fi_d;
    assign ph_a    = (fi_rise && cf) ? 2'd0 : ph;
    assign CF_o    = cf;

    // Field edge tracking, color-frame toggle and free-running phase counter
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            fi_d <= 1'b0;
            cf   <= 1'b0;
            ph   <= 2'd0;
        end else if (CK_EE_i) begin
            fi_d <= FI_i;
            if (fi_rise)
                cf <= ~cf;
            ph <= ph_a + 2'd1;
        end
    end

    // Stage 1: capture strobes, pixel data and the phase that this sample takes
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            s1_sync  <= 1'b1;
            s1_blank <= 1'b1;
            s1_burst <= 1'b0;
            s1_y     <= 8'd0;
            s1_u     <= 8'd0;
            s1_v     <= 8'd0;
            s1_ph    <= 2'd0;
        end else if (CK_EE_i) begin
            s1_sync  <= SYNC_i;
            s1_blank <= BLANK_i;
            s1_burst <= BURST_i;
            s1_y     <= Y_i;
            s1_u     <= U_i;
            s1_v     <= V_i;
            s1_ph    <= ph_a;
        end
    end

    // Luma scaling, chroma/burst term by phase and priority select decode
    always_comb begin
        luma_code   = BLACK + {1'b0, s1_y, 1'b0} + {7'd0, s1_y[7:5]};
        u9          = {s1_u[7], s1_u};
        v9          = {s1_v[7], s1_v};
        chroma_term = 9'sd0;
        burst_term  = 9'sd0;
        case (s1_ph)
            2'd0: begin
                chroma_term = u9;
                burst_term  = -BURST_AMP;
            end
            2'd1: chroma_term = v9;
            2'd2: begin
                chroma_term = -u9;
                burst_term  = BURST_AMP;
            end
            default: chroma_term = -v9;
        endcase
        term = s1_burst ? burst_term : chroma_term;
        if (!s1_sync)
            sel = SEL_SYNC;
        else if (s1_burst)
            sel = SEL_BURST;
        else if (s1_blank)
            sel = SEL_BLANK;
        else
            sel = SEL_ACTIVE;
    end

    // Stage 2: hold luma code, selected term and select
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            s2_luma <= BLACK;
            s2_term <= 9'sd0;
            s2_sel  <= SEL_BLANK;
            s2_ph   <= 2'd0;
        end else if (CK_EE_i) begin
            s2_luma <= luma_code;
            s2_term <= term;
            s2_sel  <= sel;
            s2_ph   <= s1_ph;
        end
    end

    // Level mux, signed sum and clamp to the DAC range
    always_comb begin
        sum = 12'sd0;
        case (s2_sel)
            SEL_SYNC:  sum = $signed({2'b00, SYNC_TIP});
            SEL_BURST: sum = $signed({2'b00, BLANK_LVL}) + {{3{s2_term[8]}}, s2_term};
            SEL_BLANK: sum = $signed({2'b00, BLANK_LVL});
            default:   sum = $signed({2'b00, s2_luma}) + {{3{s2_term[8]}}, s2_term};
        endcase
        if (sum < 12'sd0)
            sat = 10'd0;
        else if (sum > 12'sd1023)
            sat = 10'd1023;
        else
            sat = sum[9:0];
    end

    // Stage 3: register the DAC code and its phase tag
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            CVBS_o <= BLANK_LVL;
            PH_o   <= 2'd0;
        end else if (CK_EE_i) begin
            CVBS_o <= sat;
            PH_o   <= s2_ph;
        end
    end

endmodule

// File: tb/tb_ntsc_cvbs_enc.sv
// tb_ntsc_cvbs_enc: directed bench for ntsc_cvbs_enc with a scoreboard queue.
// Expected codes come from a behavioural model of the level equations or from
// fixed constants where the phase is known; they are compared when the sample
// reaches the output three enabled cycles later.

module tb_ntsc_cvbs_enc;

`ifdef NTSC_CVBS_SETUP_EN
    localparam int BLACK_EXP = 298;
`else
    localparam int BLACK_EXP = 256;
`endif

    typedef struct {
        int cvbs;
        int ph;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sync_n;
    logic       blank;
    logic       burst;
    logic       fi;
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
    logic [9:0] cvbs;
    logic [1:0] ph_tag;
    logic       cf_flag;

    int   errors;
    int   checks;
    exp_t sb[$];
    exp_t last;
    int   m_ph;
    int   m_cf;
    int   m_fi_d;

    ntsc_cvbs_enc dut (
        .CK_i    (clk),
        .AR_i    (rst),
        .CK_EE_i (en),
        .SYNC_i  (sync_n),
        .BLANK_i (blank),
        .BURST_i (burst),
        .FI_i    (fi),
        .Y_i     (y),
        .U_i     (u),
        .V_i     (v),
        .CVBS_o  (cvbs),
        .PH_o    (ph_tag),
        .CF_o    (cf_flag)
    );

    // 4fsc clock, 10 ns period for simulation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Expected DAC code straight from the level equations
    function automatic int modelCvbs(input logic s, input logic bu, input logic bl,
                                     input logic [7:0] yy, input logic [7:0] uu,
                                     input logic [7:0] vv, input int pha);
        int su;
        int sv;
        int c;
        int r;
        su = $signed(uu);
        sv = $signed(vv);
        if (!s)
            return 16;
        if (bu)
            return 256 + ((pha == 0) ? -112 : (pha == 2) ? 112 : 0);
        if (bl)
            return 256;
        case (pha)
            0: c = su;
            1: c = sv;
            2: c = -su;
            default: c = -sv;
        endcase
        r = BLACK_EXP + 2 * int'(yy) + (int'(yy) >> 5) + c;
        if (r < 0)
            r = 0;
        if (r > 1023)
            r = 1023;
        return r;
    endfunction

    task automatic resetModel();
        exp_t e;
        m_ph   = 0;
        m_cf   = 0;
        m_fi_d = 0;
        sb.delete();
        e.cvbs = 256;
        e.ph   = 0;
        sb.push_back(e);
        sb.push_back(e);
        last = e;
    endtask

    // One clock of stimulus; fixed_cvbs/fixed_ph >= 0 override the model
    task automatic applyStimulus(input logic s, input logic bl, input logic bu, input logic f,
                                 input logic e_n, input logic [7:0] yy, input logic [7:0] uu,
                                 input logic [7:0] vv, input int fixed_cvbs, input int fixed_ph);
        exp_t e;
        exp_t o;
        int   rise;
        int   pha;
        sync_n = s;
        blank  = bl;
        burst  = bu;
        fi     = f;
        en     = e_n;
        y      = yy;
        u      = uu;
        v      = vv;
        @(posedge clk);
        #1;
        if (e_n) begin
            rise   = (f && !m_fi_d) ? 1 : 0;
            pha    = (rise == 1 && m_cf == 1) ? 0 : m_ph;
            e.cvbs = (fixed_cvbs >= 0) ? fixed_cvbs : modelCvbs(s, bu, bl, yy, uu, vv, pha);
            e.ph   = (fixed_ph >= 0) ? fixed_ph : pha;
            sb.push_back(e);
            if (rise == 1)
                m_cf = 1 - m_cf;
            m_ph   = (pha + 1) % 4;
            m_fi_d = f ? 1 : 0;
            if (sb.size() >= 3) begin
                o = sb.pop_front();
                checkOutput("cvbs", 32'(cvbs), 32'(o.cvbs));
                checkOutput("ph", 32'(ph_tag), 32'(o.ph));
                last = o;
            end
        end else begin
            checkOutput("cvbs_hold", 32'(cvbs), 32'(last.cvbs));
            checkOutput("ph_hold", 32'(ph_tag), 32'(last.ph));
        end
        checkOutput("cf", 32'(cf_flag), 32'(m_cf));
    endtask

    // Directed sequence
    initial begin
        int burst_exp[8];
        int act1_exp[4];
        int act2_exp[4];
        errors = 0;
        checks = 0;
        burst_exp = '{144, 256, 368, 256, 144, 256, 368, 256};
`ifdef NTSC_CVBS_SETUP_EN
        act1_exp = '{398, 298, 198, 298};
        act2_exp = '{687, 942, 943, 688};
`else
        act1_exp = '{356, 256, 156, 256};
        act2_exp = '{645, 900, 901, 646};
`endif
        rst    = 1'b1;
        en     = 1'b1;
        sync_n = 1'b1;
        blank  = 1'b1;
        burst  = 1'b0;
        fi     = 1'b0;
        y      = 8'd0;
        u      = 8'd0;
        v      = 8'd0;
        #2;
        checkOutput("rst_cvbs", 32'(cvbs), 32'd256);
        checkOutput("rst_ph", 32'(ph_tag), 32'd0);
        checkOutput("rst_cf", 32'(cf_flag), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();

        // Blanking after release
        repeat (4) applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 256, -1);

        // Sync tip pulse, then back to blanking
        repeat (10) applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 16, -1);
        repeat (6) applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 256, -1);

        // First FI rise sets the color frame
        applyStimulus(1, 1, 0, 1, 1, 0, 0, 0, 256, -1);
        checkOutput("cf_first_rise", 32'(cf_flag), 32'd1);
        repeat (2) applyStimulus(1, 1, 0, 1, 1, 0, 0, 0, 256, -1);
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 256, -1);

        // Second FI rise with burst: phase restarts at 0, frame flag clears
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 1, 1, 1, 0, 0, 0, burst_exp[i], i % 4);
            if (i == 0)
                checkOutput("cf_second_rise", 32'(cf_flag), 32'd0);
        end

        // Active video: Y=0, U=100, V=0
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, 0, 1, 1, 8'd0, 8'd100, 8'd0, act1_exp[i], i);

        // Active video: Y=255, U=-128, V=127
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, 0, 1, 1, 8'd255, 8'h80, 8'd127, act2_exp[i], i);

        repeat (3) applyStimulus(1, 1, 0, 1, 1, 0, 0, 0, -1, -1);

        // Clock-enable gating with an FI rise landing on a disabled cycle
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, (i == 9) ? 1'b1 : 1'b0, (i == 3) ? 1'b0 : 1'b1,
                          (i % 3 != 1) ? 1'b1 : 1'b0,
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), -1, -1);
        end
        repeat (3) applyStimulus(1, 1, 0, 1, 1, 0, 0, 0, -1, -1);

        // Reset asserted between edges in the middle of active video
        repeat (2) applyStimulus(1, 0, 0, 1, 1, 8'd200, 8'd50, 8'd20, -1, -1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_cvbs", 32'(cvbs), 32'd256);
        checkOutput("async_rst_ph", 32'(ph_tag), 32'd0);
        checkOutput("async_rst_cf", 32'(cf_flag), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        repeat (5) applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 256, -1);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ntsc_cvbs_enc.md
# ntsc_cvbs_enc

Composite video (CVBS) level encoder that sits directly downstream of the NTSC timing generator. It consumes the generator's SYNC/BLANK/BURST/FI strobes plus a YUV pixel stream and produces a 10-bit DAC code at 4fsc. The subcarrier is synthesised by direct 4fsc sampling: the chroma term rotates +U, +V, −U, −V. Color-frame phase is locked to the FI field flag.

## Interface
- No parameters; levels are fixed localparams, listed under Operation.
- CK_i  in  1  4fsc clock (14.318 MHz), rising edge.
- AR_i  in  1  asynchronous reset, active-high.
- CK_EE_i  in  1  clock enable, same meaning as the timing generator's; tie 1 at 4fsc.
- SYNC_i  in  1  0 = sync tip (timing generator SYNC_o).
- BLANK_i  in  1  1 = blanking.
- BURST_i  in  1  1 = color burst gate.
- FI_i  in  1  field flag (timing generator FI_o).
- Y_i  in  8  luma, unsigned, 0 = black, 255 = white.
- U_i  in  8  B−Y, two's complement.
- V_i  in  8  R−Y, two's complement.
- CVBS_o  out  10  DAC code, unsigned.
- PH_o  out  2  subcarrier phase tag of the sample currently on CVBS_o.
- CF_o  out  1  color-frame flag; toggles once per frame.

## Operation
- Levels (codes): SYNC_TIP = 16, BLANK_LVL = 256, BLACK = 298 (setup on), BURST_AMP = 112.
- Luma code = BLACK + 2·Y + (Y>>5), giving 298..815.
- FI edge detect: FI_D holds the previous FI_i. A rise is FI_i & ~FI_D.
- On a rise, CF toggles.
- Phase counter PH (2 bit):
  - In each enabled cycle, the sample captured that cycle takes phase PH_a. PH_a = 0 if (rise & CF==1), else PH.
  - PH then loads PH_a + 1, mod 4.
  - Because 910 samples per line ≡ 2 mod 4, the phase inverts every line with no per-line reset. The 4-field sequence repeats every 2 frames.
- Chroma term by phase: 0 → +U, 1 → +V, 2 → −U, 3 → −V.
  - Use 9-bit signed arithmetic so that −(−128) = +128.
- Burst term by phase: 0 → −112, 1 → 0, 2 → +112, 3 → 0. This places burst on the −U axis (180°).
- Output select, priority order:
  1. SYNC_i = 0 → SYNC_TIP.
  2. Else BURST_i = 1 → BLANK_LVL + burst term, giving 144/256/368/256.
  3. Else BLANK_i = 1 → BLANK_LVL.
  4. Else → luma + chroma term.
- Sum width is 12-bit signed; saturate to 0..1023. Saturation is unreachable with the listed levels but must be implemented.
- Pipeline:
  - S1: register the inputs and PH_a.
  - S2: register the luma code, the selected chroma/burst term and the decoded select.
  - S3: sum, saturate, mux, then register CVBS_o and PH_o.
- CK_EE_i = 0 freezes every register, including PH, CF and FI_D.

## Timing
- Latency is exactly 3 enabled cycles from input to CVBS_o. Strobes and pixel data travel together, so no realignment is needed relative to the timing generator.
- Reset values:
  - CVBS_o = 256, PH_o = 0, CF_o = 0.
  - PH = 0, FI_D = 0.
  - All pipeline stages are loaded with the blank select.
- FI_D resets to 0, so FI_i = 1 at reset release counts as a rise in the first enabled cycle.
- A reset asserted mid-line forces the reset values immediately (asynchronous). The first valid output appears at the 3rd enabled edge after release.
- If SYNC_i = 0 and BURST_i = 1 together, sync wins.
- If BURST_i = 1 while BLANK_i = 0, burst still wins.
- An FI rise coinciding with CK_EE_i = 0 is not seen until the next enabled cycle, because FI_D is frozen.

## Configuration
- Macro NTSC_CVBS_SETUP_EN.
- Defined: 7.5 IRE setup; BLACK = 298; luma range 298..815 (NTSC-M, US).
- Undefined: no setup; BLACK = BLANK_LVL = 256; luma range 256..773 (NTSC-J).
- Sync, burst, chroma terms and latency are unchanged in both builds.

## Test plan
- Reset and release with all strobes inactive except BLANK_i = 1 → CVBS_o = 256, PH_o = 0, CF_o = 0; output stays 256.
- SYNC_i = 0 for 10 cycles, CK_EE_i = 1 → CVBS_o = 16 starting exactly 3 cycles later, for 10 cycles, then returns to 256.
- BURST_i = 1, BLANK_i = 1, with phase cleared by an FI rise while CF = 1 → CVBS_o sequence 144, 256, 368, 256 repeating, with PH_o = 0, 1, 2, 3.
- Active video, Y = 0, U = 100, V = 0, setup on → 398, 298, 198, 298. Same stimulus with setup off → 356, 256, 156, 256.
- Active video, Y = 255, U = −128, V = 127 → phase 0: 687, 1: 942, 2: 943, 3: 688.
- Gating and framing:
  - Toggle CK_EE_i 1/0 → output and PH advance only on enabled cycles.
  - Two FI rises → CF_o goes 1 then 0.
  - The second rise forces phase 0 on that sample.
